// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW, branch redirect, dmem busy and halt.
// Optional macro PIPE_FORWARD_EN: forwarding present, only load-use hazards stall.
module pipe_hazard_ctrl #(
    parameter int REG_BITS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] rs_id,
    input  logic [REG_BITS-1:0] rt_id,
    input  logic                rs_used,
    input  logic                rt_used,
    input  logic [REG_BITS-1:0] dst_DX,
    input  logic                reg_write_DX,
    input  logic                mem_read_DX,
    input  logic [REG_BITS-1:0] dst_XM,
    input  logic                reg_write_XM,
    input  logic                branchCond,
    input  logic                halt_XM,
    input  logic                dmem_busy,
    output logic                pc_we,
    output logic                ifid_we,
    output logic                ifid_flush,
    output logic                idex_we,
    output logic                idex_flush,
    output logic                exmem_we,
    output logic                exmem_flush,
    output logic                memwb_flush,
    output logic                halted,
    output logic [CNT_W-1:0]    stall_cycles
);

    // state   | meaning
    // RUN     | pipe flowing; hazards resolved by stall/bubble/squash
    // MEMWAIT | data memory busy, whole pipe frozen, WB gets bubbles
    // HALTED  | halt retired; everything frozen until reset
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_match_dx;
    logic w_raw_load;
    logic w_raw;

    assign w_match_dx = (rs_used && (rs_id == dst_DX)) || (rt_used && (rt_id == dst_DX));
    assign w_raw_load = mem_read_DX && reg_write_DX && w_match_dx;

`ifdef PIPE_FORWARD_EN
    assign w_raw = w_raw_load;
`else
    logic w_match_xm;
    assign w_match_xm = (rs_used && (rs_id == dst_XM)) || (rt_used && (rt_id == dst_XM));
    // Without forwarding any in-flight producer in EX or MEM blocks decode.
    assign w_raw = w_raw_load
                || (reg_write_DX && w_match_dx)
                || (reg_write_XM && w_match_xm);
`endif

    // MEMWAIT without busy is the release cycle and behaves exactly like RUN,
    // so a branch or halt that waited under busy is serviced here.
    always_comb begin
        w_state_nxt = ST_RUN;
        case (r_state)
            ST_HALTED: w_state_nxt = ST_HALTED;
            default: begin
                if (dmem_busy) begin
                    w_state_nxt = ST_MEMWAIT;
                end else if (halt_XM) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (r_state == ST_HALTED) begin
            pc_we = 1'b0;
        end else if (dmem_busy) begin
            memwb_flush = 1'b1;
        end else if (halt_XM) begin
            // MEM/WB takes the halt so it retires; everything upstream freezes.
            pc_we = 1'b0;
        end else if (branchCond) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            idex_we     = 1'b1;
            exmem_we    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_raw) begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            exmem_we   = 1'b1;
        end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_we && (r_state != ST_HALTED) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign halted       = (r_state == ST_HALTED);
    assign stall_cycles = r_stall_cnt;

endmodule
